// File: rtl/alu_pkg.sv
// Shared types for the ALU issue path: ALU op codes, ARM condition codes,
// data-processing opcodes, src1 select values, the issue FSM state and decode record.
package alu_pkg;

  typedef enum logic [3:0] {
    PLUS      = 4'd0,
    cPLUS     = 4'd1,
    MINUS     = 4'd2,
    revMINUS  = 4'd3,
    cMINUS    = 4'd4,
    revcMINUS = 4'd5,
    MULT      = 4'd6,
    AND       = 4'd7,
    XOR       = 4'd8,
    OR        = 4'd9,
    NOT       = 4'd10,
    CLEAR     = 4'd11,
    RRX       = 4'd12
  } alu_op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'ha, COND_LT = 4'hb,
    COND_GT = 4'hc, COND_LE = 4'hd, COND_AL = 4'he, COND_NV = 4'hf
  } arm_cond_e;

  typedef enum logic [3:0] {
    DP_AND = 4'h0, DP_EOR = 4'h1, DP_SUB = 4'h2, DP_RSB = 4'h3,
    DP_ADD = 4'h4, DP_ADC = 4'h5, DP_SBC = 4'h6, DP_RSC = 4'h7,
    DP_TST = 4'h8, DP_TEQ = 4'h9, DP_CMP = 4'ha, DP_CMN = 4'hb,
    DP_ORR = 4'hc, DP_MOV = 4'hd, DP_BIC = 4'he, DP_MVN = 4'hf
  } dp_opc_e;

  localparam logic [1:0] SRC1_RN   = 2'd0;
  localparam logic [1:0] SRC1_ZERO = 2'd1;
  localparam logic [1:0] SRC1_RM   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } issue_state_e;

  typedef struct packed {
    alu_op_e    op;
    logic [1:0] src1_sel;
    logic [3:0] rn;
    logic [3:0] rm;
    logic [3:0] rd;
    logic       wr_rd;
    logic       set_flags;
    logic       keep_v;
  } issue_dec_t;

  function automatic alu_op_e dp_alu_op(dp_opc_e opc);
    alu_op_e op;
    case (opc)
      DP_AND, DP_TST: op = AND;
      DP_EOR, DP_TEQ: op = XOR;
      DP_SUB, DP_CMP: op = MINUS;
      DP_RSB:         op = revMINUS;
      DP_ADD, DP_CMN: op = PLUS;
      DP_ADC:         op = cPLUS;
      DP_SBC:         op = cMINUS;
      DP_RSC:         op = revcMINUS;
      DP_ORR, DP_MOV: op = OR;
      DP_BIC:         op = CLEAR;
      DP_MVN:         op = NOT;
      default:        op = PLUS;
    endcase
    return op;
  endfunction

  function automatic logic dp_is_compare(dp_opc_e opc);
    return (opc == DP_TST) || (opc == DP_TEQ) || (opc == DP_CMP) || (opc == DP_CMN);
  endfunction

  // Logical ops carry their C from the shifter and leave V alone.
  function automatic logic dp_is_logical(dp_opc_e opc);
    return (opc == DP_AND) || (opc == DP_EOR) || (opc == DP_TST) || (opc == DP_TEQ) ||
           (opc == DP_ORR) || (opc == DP_MOV) || (opc == DP_BIC) || (opc == DP_MVN);
  endfunction

endpackage

// File: rtl/dp_issue_ctrl_if.sv
// Bundle between the issue controller (slave) and its fetch / ALU / register-file
// environment (master).
interface dp_issue_ctrl_if
  import alu_pkg::*;
#(
  parameter int ALU_OP_W = 4
);

  // Fetch handshake: an instruction transfers on a rising edge where instr_valid
  // and instr_ready are both high; instr is ignored otherwise and never buffered.
  logic [31:0]         instr;
  logic                instr_valid;
  logic                instr_ready;

  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_carr;
  logic [1:0]          src1_sel;
  logic [3:0]          rn_addr;
  logic [3:0]          rm_addr;
  logic [3:0]          rd_addr;
  logic [3:0]          alu_nzvc;
  logic                rd_we;
  logic [3:0]          flags_q;
  logic                done;
  logic                skipped;
  logic                illegal;
  issue_state_e        state_dbg;

  modport slave (
    input  instr, instr_valid, alu_nzvc,
    output instr_ready, alu_op, alu_carr, src1_sel, rn_addr, rm_addr, rd_addr,
           rd_we, flags_q, done, skipped, illegal, state_dbg
  );

  modport master (
    output instr, instr_valid, alu_nzvc,
    input  instr_ready, alu_op, alu_carr, src1_sel, rn_addr, rm_addr, rd_addr,
           rd_we, flags_q, done, skipped, illegal, state_dbg
  );

endinterface

// File: rtl/cond_check.sv
// ARM condition-code evaluator: pass is high when cond holds for the given NZVC.
// Purely combinational so branch logic can share it.
module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzvc,
  output logic       pass
);

  logic n, z, v, c;
  assign {n, z, v, c} = nzvc;

  always_comb begin
    pass = 1'b0;
    case (arm_cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/dp_issue_ctrl.sv
// Issue controller for ARM data-processing / multiply instructions: condition check,
// decode to ALU controls, one-cycle execute, writeback strobe and NZVC flag update.
module dp_issue_ctrl
  import alu_pkg::*;
#(
  parameter int ALU_OP_W = 4
)(
  input  logic            clk,
  input  logic            rst_n,
  dp_issue_ctrl_if.slave  bus
);

  issue_state_e state;
  logic [31:0]  ir_q;
  logic [3:0]   flags_q;
  alu_op_e      alu_op_q;
  logic [1:0]   src1_q;
  logic [3:0]   rn_q;
  logic [3:0]   rm_q;
  logic [3:0]   rd_q;
  logic         wr_rd_q;
  logic         set_flags_q;
  logic         keep_v_q;
  logic         rd_we_q;
  logic         done_wb_q;

  logic         cond_pass;
  logic         is_mul;
  logic         is_dp;
  logic         legal;
  dp_opc_e      opc;
  issue_dec_t   dec;

  cond_check u_cond_check (
    .cond (ir_q[31:28]),
    .nzvc (flags_q),
    .pass (cond_pass)
  );

  assign opc    = dp_opc_e'(ir_q[24:21]);
  assign is_mul = (ir_q[27:22] == 6'd0) && (ir_q[7:4] == 4'b1001);
  assign is_dp  = (ir_q[27:26] == 2'b00);
  assign legal  = is_mul || is_dp;

  always_comb begin
    dec = '0;
    if (is_mul) begin
      dec.op        = MULT;
      dec.src1_sel  = SRC1_RN;
      dec.rd        = ir_q[19:16];
      dec.rn        = ir_q[3:0];
      dec.rm        = ir_q[11:8];
      dec.wr_rd     = 1'b1;
      dec.set_flags = ir_q[20];
      dec.keep_v    = 1'b0;
    end else begin
      dec.op        = dp_alu_op(opc);
      dec.src1_sel  = (opc == DP_MOV) ? SRC1_ZERO :
                      (opc == DP_MVN) ? SRC1_RM   : SRC1_RN;
      dec.rn        = ir_q[19:16];
      dec.rd        = ir_q[15:12];
      dec.rm        = ir_q[3:0];
      // Compare ops only exist to set flags, so S is implied and Rd is never written.
      dec.wr_rd     = !dp_is_compare(opc);
      dec.set_flags = ir_q[20] || dp_is_compare(opc);
      dec.keep_v    = dp_is_logical(opc);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ir_q        <= '0;
      flags_q     <= '0;
      alu_op_q    <= PLUS;
      src1_q      <= SRC1_RN;
      rn_q        <= '0;
      rm_q        <= '0;
      rd_q        <= '0;
      wr_rd_q     <= 1'b0;
      set_flags_q <= 1'b0;
      keep_v_q    <= 1'b0;
      rd_we_q     <= 1'b0;
      done_wb_q   <= 1'b0;
    end else begin
      rd_we_q   <= 1'b0;
      done_wb_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            ir_q  <= bus.instr;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (cond_pass && legal) begin
            alu_op_q    <= dec.op;
            src1_q      <= dec.src1_sel;
            rn_q        <= dec.rn;
            rm_q        <= dec.rm;
            rd_q        <= dec.rd;
            wr_rd_q     <= dec.wr_rd;
            set_flags_q <= dec.set_flags;
            keep_v_q    <= dec.keep_v;
            state       <= ST_EXEC;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          rd_we_q   <= wr_rd_q;
          done_wb_q <= 1'b1;
          state     <= ST_WB;
        end
        ST_WB: begin
          if (set_flags_q) begin
            flags_q <= keep_v_q ? {bus.alu_nzvc[3:2], flags_q[1], bus.alu_nzvc[0]}
                                : bus.alu_nzvc;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Skip and illegal outcomes are known during DECODE itself, so they are flagged
  // in that cycle from the state register rather than a cycle later.
  assign bus.skipped     = (state == ST_DECODE) && !cond_pass;
  assign bus.illegal     = (state == ST_DECODE) && cond_pass && !legal;
  assign bus.done        = done_wb_q || bus.skipped || bus.illegal;

  assign bus.instr_ready = (state == ST_IDLE);
  assign bus.alu_op      = ALU_OP_W'(alu_op_q);
  assign bus.alu_carr    = flags_q[0];
  assign bus.src1_sel    = src1_q;
  assign bus.rn_addr     = rn_q;
  assign bus.rm_addr     = rm_q;
  assign bus.rd_addr     = rd_q;
  assign bus.rd_we       = rd_we_q;
  assign bus.flags_q     = flags_q;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_dp_issue_ctrl.sv
// Bench for dp_issue_ctrl: directed test-plan steps followed by random instructions,
// all checked against an instruction-level reference model of the issue controller.
module tb_dp_issue_ctrl;

  localparam int K_EXEC = 0;
  localparam int K_SKIP = 1;
  localparam int K_ILL  = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [3:0] m_flags;

  // ARM opcode -> ALU controller code, in opcode order AND..MVN.
  logic [3:0] op_tab [16] = '{4'd7, 4'd8, 4'd2, 4'd3, 4'd0, 4'd1, 4'd4, 4'd5,
                              4'd7, 4'd8, 4'd2, 4'd0, 4'd9, 4'd9, 4'd11, 4'd10};

  dp_issue_ctrl_if #(.ALU_OP_W(4)) bus ();

  dp_issue_ctrl #(.ALU_OP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(
    input  logic [31:0] w,
    input  logic [3:0]  f,
    input  logic [3:0]  nzvc,
    output int          kind,
    output logic [3:0]  op,
    output logic [1:0]  s1,
    output logic [3:0]  rn,
    output logic [3:0]  rm,
    output logic [3:0]  rd,
    output bit          we,
    output logic [3:0]  nf
  );
    bit n, z, v, c, pass, mul, dp, cmp, logical;
    logic [3:0] opc;
    {n, z, v, c} = f;
    case (w[31:28])
      4'h0: pass = z;
      4'h1: pass = !z;
      4'h2: pass = c;
      4'h3: pass = !c;
      4'h4: pass = n;
      4'h5: pass = !n;
      4'h6: pass = v;
      4'h7: pass = !v;
      4'h8: pass = c && !z;
      4'h9: pass = !c || z;
      4'ha: pass = (n == v);
      4'hb: pass = (n != v);
      4'hc: pass = !z && (n == v);
      4'hd: pass = z || (n != v);
      4'he: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    opc = w[24:21];
    mul = (w[27:22] == 6'd0) && (w[7:4] == 4'd9);
    dp  = (w[27:26] == 2'd0);
    nf = f; op = 4'd0; s1 = 2'd0; rn = 4'd0; rm = 4'd0; rd = 4'd0; we = 1'b0;
    if (!pass) kind = K_SKIP;
    else if (!mul && !dp) kind = K_ILL;
    else begin
      kind = K_EXEC;
      if (mul) begin
        op = 4'd6; rd = w[19:16]; rn = w[3:0]; rm = w[11:8]; we = 1'b1;
        if (w[20]) nf = nzvc;
      end else begin
        op = op_tab[opc];
        s1 = (opc == 4'd13) ? 2'd1 : (opc == 4'd15) ? 2'd2 : 2'd0;
        rn = w[19:16]; rd = w[15:12]; rm = w[3:0];
        cmp = (opc >= 4'd8) && (opc <= 4'd11);
        logical = opc inside {4'd0, 4'd1, 4'd8, 4'd9, 4'd12, 4'd13, 4'd14, 4'd15};
        we = !cmp;
        if (w[20] || cmp) nf = logical ? {nzvc[3:2], f[1], nzvc[0]} : nzvc;
      end
    end
  endtask

  // Issue one instruction at a negedge and follow it cycle by cycle; returns at the
  // negedge where the controller is ready again. abort pulls reset during EXEC.
  task automatic run_instr(input logic [31:0] w, input logic [3:0] nzvc, input bit abort);
    int kind, guard;
    logic [3:0] e_op, e_rn, e_rm, e_rd, e_nf;
    logic [1:0] e_s1;
    bit e_we, hold_valid;
    model_step(w, m_flags, nzvc, kind, e_op, e_s1, e_rn, e_rm, e_rd, e_we, e_nf);
    guard = 0;
    while (!bus.instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_issue", bus.instr_ready, 1'b1);
    hold_valid = ($urandom_range(0, 1) == 1);
    bus.instr = w;
    bus.instr_valid = 1'b1;
    bus.alu_nzvc = 4'($urandom);
    @(posedge clk);
    @(negedge clk);
    bus.instr = $urandom;
    bus.instr_valid = hold_valid;
    check("c1_ready", bus.instr_ready, 1'b0);
    check("c1_done", bus.done, kind != K_EXEC);
    check("c1_skipped", bus.skipped, kind == K_SKIP);
    check("c1_illegal", bus.illegal, kind == K_ILL);
    check("c1_rd_we", bus.rd_we, 1'b0);
    if (kind != K_EXEC) begin
      @(negedge clk);
      bus.instr_valid = 1'b0;
      check("skip_c2_ready", bus.instr_ready, 1'b1);
      check("skip_c2_done", bus.done, 1'b0);
      check("skip_c2_rd_we", bus.rd_we, 1'b0);
      check("skip_c2_flags", bus.flags_q, m_flags);
      return;
    end
    @(negedge clk);
    check("exec_alu_op", bus.alu_op, e_op);
    check("exec_src1_sel", bus.src1_sel, e_s1);
    check("exec_rn", bus.rn_addr, e_rn);
    check("exec_rm", bus.rm_addr, e_rm);
    check("exec_rd", bus.rd_addr, e_rd);
    check("exec_alu_carr", bus.alu_carr, m_flags[0]);
    check("exec_done", bus.done, 1'b0);
    check("exec_rd_we", bus.rd_we, 1'b0);
    bus.alu_nzvc = nzvc;
    if (abort) begin
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_done", bus.done, 1'b0);
      check("abort_rd_we", bus.rd_we, 1'b0);
      check("abort_flags", bus.flags_q, 4'b0000);
      check("abort_ready", bus.instr_ready, 1'b1);
      rst_n = 1'b1;
      bus.instr_valid = 1'b0;
      m_flags = 4'b0000;
      return;
    end
    @(negedge clk);
    check("wb_rd_we", bus.rd_we, e_we);
    check("wb_done", bus.done, 1'b1);
    check("wb_skipped", bus.skipped, 1'b0);
    check("wb_illegal", bus.illegal, 1'b0);
    check("wb_flags_old", bus.flags_q, m_flags);
    m_flags = e_nf;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("post_flags", bus.flags_q, m_flags);
    check("post_ready", bus.instr_ready, 1'b1);
    check("post_done", bus.done, 1'b0);
    check("post_rd_we", bus.rd_we, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    int sel;
    checks = 0;
    failures = 0;
    m_flags = 4'b0000;
    rst_n = 1'b0;
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    bus.alu_nzvc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.instr_ready, 1'b1);
    check("rst_flags", bus.flags_q, 4'b0000);
    check("rst_alu_op", bus.alu_op, 4'd0);
    check("rst_src1_sel", bus.src1_sel, 2'd0);
    check("rst_rn", bus.rn_addr, 4'd0);
    check("rst_rm", bus.rm_addr, 4'd0);
    check("rst_rd", bus.rd_addr, 4'd0);
    check("rst_rd_we", bus.rd_we, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_skipped", bus.skipped, 1'b0);
    check("rst_illegal", bus.illegal, 1'b0);
    check("rst_carr", bus.alu_carr, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed test-plan sequence.
    run_instr(32'hE0921003, 4'b0100, 1'b0);
    check("adds_flags", bus.flags_q, 4'b0100);
    run_instr(32'h00821003, 4'b1111, 1'b0);
    check("addeq_pass_flags", bus.flags_q, 4'b0100);
    run_instr(32'hE1520003, 4'b1001, 1'b0);
    check("cmp_flags", bus.flags_q, 4'b1001);
    run_instr(32'h00821003, 4'b0000, 1'b0);
    check("addeq_fail_flags", bus.flags_q, 4'b1001);
    run_instr(32'hE0921003, 4'b0010, 1'b0);
    run_instr(32'hE0121003, 4'b0101, 1'b0);
    check("ands_keep_v", bus.flags_q, 4'b0111);
    run_instr(32'hE1E01003, 4'b1000, 1'b0);
    run_instr(32'hE0040695, 4'b1010, 1'b0);
    run_instr(32'hEA000000, 4'b0000, 1'b0);
    check("illegal_flags", bus.flags_q, 4'b0111);
    run_instr(32'hE0921003, 4'b1100, 1'b1);

    // Random instruction mix.
    for (int i = 0; i < 160; i++) begin
      w = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 5) w[27:26] = 2'b00;
      else if (sel < 7) begin
        w[27:22] = 6'd0;
        w[7:4] = 4'b1001;
      end
      if ($urandom_range(0, 3) == 0) w[31:28] = 4'hE;
      run_instr(w, 4'($urandom), $urandom_range(0, 29) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dp_issue_ctrl.md
# dp_issue_ctrl

Sequential control block that feeds the ALU: it accepts one 32-bit ARM data-processing or multiply instruction via a valid/ready handshake. It evaluates the condition field against an internal NZCV flag register, then decodes the opcode into the ALU `controller` code, operand selects and register addresses. It issues the operation for one cycle and captures the ALU `nzvc` result into its flag register when the S bit is set. It sits between instruction fetch and the ALU/register file, and is the producer side of the ALU's `controller`/`carr` inputs and the consumer of its `nzvc` output.

## Interface
- `ALU_OP_W`, default 4: width of the ALU operation code.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `instr`  in  32  instruction word, sampled when `instr_valid && instr_ready`.
- `instr_valid`  in  1  fetch side has an instruction.
- `instr_ready`  out  1  block is in IDLE.
- `alu_op`  out  4  ALU `controller` code from the package.
- `alu_carr`  out  1  current C flag (`flags_q[0]`), fed to ALU `carr`.
- `src1_sel`  out  2  ALU src1 source: 0 = Rn, 1 = zero, 2 = Rm.
- `rn_addr`, `rm_addr`, `rd_addr`  out  4 each  register-file addresses.
- `alu_nzvc`  in  4  ALU flags {N,Z,V,C}.
- `rd_we`  out  1  register-file write strobe, one cycle.
- `flags_q`  out  4  architectural NZVC register.
- `done`  out  1  one-cycle pulse: instruction retired or skipped.
- `skipped`  out  1  qualifies `done`: condition failed.
- `illegal`  out  1  qualifies `done`: not data-processing or multiply; no effect.

## Operation
- **FSM states:** IDLE -> DECODE -> EXEC -> WB -> IDLE.
- **Condition-fail path:** DECODE returns straight to IDLE on condition fail or illegal.
- **IDLE:** `instr_ready`=1. On handshake, latch `instr` into `ir_q` and go to DECODE.
- **DECODE:** evaluate `ir_q[31:28]` against `flags_q`.
  - Use the standard ARM EQ..AL table; 1111 = never.
  - Fail -> `done`=`skipped`=1, go to IDLE.
  - Multiply if `ir_q[27:22]`=0 and `ir_q[7:4]`=1001.
  - Data-processing if `ir_q[27:26]`=00.
  - Anything else -> `done`=`illegal`=1, go to IDLE.
  - Otherwise register the decode outputs and go to EXEC.
- **Opcode map (`ir_q[24:21]`):**
  - AND->AND, EOR->XOR, SUB->MINUS, RSB->revMINUS.
  - ADD->PLUS, ADC->cPLUS, SBC->cMINUS, RSC->revcMINUS.
  - TST->AND, TEQ->XOR, CMP->MINUS, CMN->PLUS.
  - ORR->OR, MOV->OR with `src1_sel`=1, BIC->CLEAR, MVN->NOT with `src1_sel`=2.
  - Multiply -> MULT, with Rd=`ir_q[19:16]`, Rn=`ir_q[3:0]`, Rm=`ir_q[11:8]`.
  - Data-processing register fields: Rn=`[19:16]`, Rd=`[15:12]`, Rm=`[3:0]`.
- **Compare ops:** TST/TEQ/CMP/CMN never write Rd. S is treated as 1 for them.
- **EXEC:** drive `alu_op`/`src1_sel`/addresses stable for one cycle while the combinational ALU settles.
- **WB:**
  - `rd_we`=1 unless the op is a compare op.
  - If S: arithmetic ops and MULT load all four flags from `alu_nzvc`.
  - If S: logical ops (AND/EOR/TST/TEQ/ORR/MOV/BIC/MVN) load N, Z and C and keep V.
  - `done`=1; go to IDLE.
- **Reset values:** `state`=IDLE, `flags_q`=0000, `ir_q`=0, `alu_op`=PLUS, `src1_sel`=0, all addresses 0, `rd_we`/`done`/`skipped`/`illegal`=0.

## Timing
- **Handshake:** at edge 0; DECODE is cycle 1.
- **Retired instruction:** EXEC is cycle 2, WB is cycle 3. `done`+`rd_we` are asserted in cycle 3, and the `flags_q` update is visible from cycle 4.
- **Skipped/illegal instruction:** `done` in cycle 1; `instr_ready` again in cycle 2.
- **Throughput:** at most one instruction per 4 cycles. `instr_ready` is low from DECODE through WB.
- **Fetch side:** `instr_valid` held while `instr_ready`=0 is ignored; no buffering.
- **Flag hazards:** the next instruction's DECODE always sees flags written by the previous WB, because WB->IDLE->DECODE is at least 2 edges.
- **`alu_carr`:** it is `flags_q[0]` registered. It is not updated during the same instruction's EXEC.
- **Reset mid-operation:** the in-flight instruction is dropped. No `rd_we`/`done` is asserted and flags are cleared.

## Structure
- **Package `alu_pkg`:**
  - ALU op enum, 4-bit: PLUS=0, cPLUS=1, MINUS=2, revMINUS=3, cMINUS=4, revcMINUS=5, MULT=6, AND=7, XOR=8, OR=9, NOT=10, CLEAR=11, RRX=12.
  - ARM cond enum.
  - `src1_sel` constants.
  - FSM state enum.
- **Sub-module `cond_check`:** combinational, (cond[3:0], nzvc[3:0]) -> pass. It is reused later by branch logic.

## Test plan
- **Reset:** after reset, issue ADDS R1,R2,R3 (`instr`=0xE0921003). Expect `alu_op`=0, rn=2, rm=3, rd=1 in cycle 2. With `alu_nzvc`=0100 in WB, expect `rd_we`=1 and `flags_q`=0100 from cycle 4.
- **Cond pass:** Z=1, issue ADDEQ (0x00821003). Expect it to execute with `rd_we`=1 and `flags_q` unchanged (S=0).
- **Cond fail:** Z=0, issue ADDEQ (0x00821003). Expect `done`=`skipped`=1 in cycle 1, no `rd_we`, and `instr_ready` back in cycle 2.
- **Compare op:** CMP R2,R3 (0xE1520003) with `alu_nzvc`=1001. Expect `alu_op`=2, `rd_we`=0, `flags_q`=1001.
- **Logical S op:** `flags_q`=0010, issue ANDS (0xE0121003) with `alu_nzvc`=0101. Expect `flags_q`=0111 (V kept), and MVN (0xE1E01003) gives `src1_sel`=2, `alu_op`=10.
- **Multiply, illegal, reset mid-op:**
  - MUL R4,R5,R6 (0xE0040695) -> `alu_op`=6, rd=4.
  - 0xEA000000 (branch) -> `illegal`=1 in cycle 1.
  - `rst_n`=0 during EXEC -> no `done`, `flags_q`=0.
